axi_txn_limiter: RTL

//  Caps outstanding AXI4 read and write transactions ahead of a long, multi-cut bus,
//  so downstream register slices and slaves never hold more bursts than they can absorb.

---
 rtl/axi_txn_limiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/axi_txn_limiter.sv
// Outstanding-transaction limiter for AXI4: gates AW/AR handshakes against per-direction burst
// counters and offers a flush/idle handshake for draining the downstream cut chain.
package axi_txn_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axi_b_t  b;
        logic    b_valid;
        logic    ar_ready;
        axi_r_t  r;
        logic    r_valid;
    } axi_resp_t;

endpackage

module axi_txn_limiter #(
    parameter int unsigned MaxReads  = 4,
    parameter int unsigned MaxWrites = 4,
    parameter type req_t  = axi_txn_pkg::axi_req_t,
    parameter type resp_t = axi_txn_pkg::axi_resp_t,
    localparam int unsigned RdW = $clog2(MaxReads + 1),
    localparam int unsigned WrW = $clog2(MaxWrites + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  req_t           slv_req_i,
    output resp_t          slv_resp_o,
    output req_t           mst_req_o,
    input  resp_t          mst_resp_i,
    input  logic           flush_i,
    output logic           idle_o,
    output logic [RdW-1:0] rd_outstanding_o,
    output logic [WrW-1:0] wr_outstanding_o,
    output logic           err_o
);

    localparam logic [RdW-1:0] RdMax  = RdW'(MaxReads);
    localparam logic [WrW-1:0] WrMax  = WrW'(MaxWrites);
    localparam logic [RdW-1:0] RdZero = {RdW{1'b0}};
    localparam logic [WrW-1:0] WrZero = {WrW{1'b0}};
    localparam logic [RdW-1:0] RdOne  = RdW'(1'b1);
    localparam logic [WrW-1:0] WrOne  = WrW'(1'b1);

    logic [RdW-1:0] rd_cnt_r, rd_cnt_nxt_s;
    logic [WrW-1:0] wr_cnt_r, wr_cnt_nxt_s;
    logic           err_r;
    logic           aw_open_s, ar_open_s;
    logic           wr_inc_s, wr_dec_s, rd_inc_s, rd_dec_s;
    logic           wr_err_s, rd_err_s;

    // Gates are a function of registered counts and flush only, never of B/R
    assign aw_open_s = (wr_cnt_r < WrMax) && !flush_i;
    assign ar_open_s = (rd_cnt_r < RdMax) && !flush_i;

    assign wr_inc_s = slv_req_i.aw_valid & aw_open_s & mst_resp_i.aw_ready;
    assign wr_dec_s = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign rd_inc_s = slv_req_i.ar_valid & ar_open_s & mst_resp_i.ar_ready;
    assign rd_dec_s = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    // Combinational pass-through with AW/AR valid/ready gated
    always_comb begin
        mst_req_o           = slv_req_i;
        slv_resp_o          = mst_resp_i;
        mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open_s;
        mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open_s;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open_s;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open_s;
    end

    // Write counter next state; a retire at zero saturates and flags an error
    always_comb begin
        wr_cnt_nxt_s = wr_cnt_r;
        case ({wr_inc_s, wr_dec_s})
            2'b10: wr_cnt_nxt_s = wr_cnt_r + WrOne;
            2'b01: begin
                if (wr_cnt_r == WrZero) begin
                    wr_cnt_nxt_s = WrZero;
                end else begin
                    wr_cnt_nxt_s = wr_cnt_r - WrOne;
                end
            end
            default: wr_cnt_nxt_s = wr_cnt_r;
        endcase
        if (wr_dec_s && (wr_cnt_r == WrZero)) begin
            wr_err_s = 1'b1;
        end else begin
            wr_err_s = 1'b0;
        end
    end

    // Read counter next state; only the last R beat of a burst retires it
    always_comb begin
        rd_cnt_nxt_s = rd_cnt_r;
        case ({rd_inc_s, rd_dec_s})
            2'b10: rd_cnt_nxt_s = rd_cnt_r + RdOne;
            2'b01: begin
                if (rd_cnt_r == RdZero) begin
                    rd_cnt_nxt_s = RdZero;
                end else begin
                    rd_cnt_nxt_s = rd_cnt_r - RdOne;
                end
            end
            default: rd_cnt_nxt_s = rd_cnt_r;
        endcase
        if (rd_dec_s && (rd_cnt_r == RdZero)) begin
            rd_err_s = 1'b1;
        end else begin
            rd_err_s = 1'b0;
        end
    end

    // Counter and sticky-error registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_r <= WrZero;
            rd_cnt_r <= RdZero;
            err_r    <= 1'b0;
        end else begin
            wr_cnt_r <= wr_cnt_nxt_s;
            rd_cnt_r <= rd_cnt_nxt_s;
            err_r    <= err_r | wr_err_s | rd_err_s;
        end
    end

    assign wr_outstanding_o = wr_cnt_r;
    assign rd_outstanding_o = rd_cnt_r;
    assign err_o            = err_r;
    assign idle_o           = (wr_cnt_r == WrZero) && (rd_cnt_r == RdZero);

endmodule
